// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit scheduler: FSM encoding, line levels, timing default.
// The PARITY state exists only when UART_TX_SCHED_PARITY_EN is defined.
package uart_pkg;

    localparam int unsigned TICKS_PER_BIT_DEF = 16;

    localparam logic LINE_IDLE  = 1'b1;
    localparam logic LINE_START = 1'b0;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef UART_TX_SCHED_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request searching upward from ptr+1 (mod N_REQ).
module rr_arbiter #(
    parameter int unsigned N_REQ  = 4,
    parameter int unsigned NB_IDX = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0]  req,
    input  logic [NB_IDX-1:0] ptr,
    output logic [N_REQ-1:0]  grant,
    output logic [NB_IDX-1:0] idx,
    output logic              any
);

    logic [N_REQ-1:0] req_rot;

    // Walk from farthest to nearest candidate so the nearest hit wins.
    always_comb begin
        idx     = '0;
        any     = 1'b0;
        req_rot = '0;
        for (int i = int'(N_REQ); i >= 1; i--) begin
            req_rot = req >> ((int'(ptr) + i) % int'(N_REQ));
            if (req_rot[0]) begin
                idx = NB_IDX'((int'(ptr) + i) % int'(N_REQ));
                any = 1'b1;
            end
        end
        grant = any ? (N_REQ'(1) << idx) : '0;
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin shared UART transmitter: arbitrates N_REQ byte sources onto one TX line.
// Optional even-parity bit enabled by defining UART_TX_SCHED_PARITY_EN.
module uart_tx_scheduler
    import uart_pkg::*;
#(
    parameter int unsigned N_REQ         = 4,
    parameter int unsigned NB_DATA       = 8,
    parameter int unsigned TICKS_PER_BIT = TICKS_PER_BIT_DEF,
    parameter int unsigned NB_IDX        = $clog2(N_REQ)
) (
    input  logic                     i_clock,
    input  logic                     i_reset,
    input  logic                     i_tick,
    input  logic [N_REQ-1:0]         i_req,
    input  logic [N_REQ*NB_DATA-1:0] i_data,
    output logic [N_REQ-1:0]         o_grant,
    output logic [NB_IDX-1:0]        o_grant_idx,
    output logic                     o_busy,
    output logic                     o_done,
    output logic                     o_tx
);

    localparam int unsigned TW = (TICKS_PER_BIT > 1) ? $clog2(TICKS_PER_BIT) : 1;
    localparam int unsigned BW = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;

    state_t               state, state_d;
    logic [TW-1:0]        tick_cnt, tick_cnt_d;
    logic [BW-1:0]        bit_cnt, bit_cnt_d;
    logic [NB_DATA-1:0]   shift_reg, shift_d;
    logic [NB_IDX-1:0]    ptr, ptr_d;
    logic [N_REQ-1:0]     grant_d;
    logic [NB_IDX-1:0]    grant_idx_d;
    logic                 busy_d, done_d, tx_d;
    logic                 bit_end;
    logic [N_REQ-1:0]     arb_grant;
    logic [NB_IDX-1:0]    arb_idx;
    logic                 arb_any;
    logic [NB_DATA-1:0]   arb_byte;
`ifdef UART_TX_SCHED_PARITY_EN
    logic                 parity, parity_d;
`endif

    rr_arbiter #(
        .N_REQ  (N_REQ),
        .NB_IDX (NB_IDX)
    ) u_arb (
        .req   (i_req),
        .ptr   (ptr),
        .grant (arb_grant),
        .idx   (arb_idx),
        .any   (arb_any)
    );

    assign arb_byte = NB_DATA'(i_data >> (int'(arb_idx) * int'(NB_DATA)));
    assign bit_end  = i_tick && (tick_cnt == TW'(TICKS_PER_BIT - 1));

    // Next-state, counters and next values of all registered outputs.
    always_comb begin
        state_d     = state;
        tick_cnt_d  = tick_cnt;
        bit_cnt_d   = bit_cnt;
        shift_d     = shift_reg;
        ptr_d       = ptr;
        grant_d     = '0;
        grant_idx_d = o_grant_idx;
        busy_d      = o_busy;
        done_d      = 1'b0;
        tx_d        = LINE_IDLE;
`ifdef UART_TX_SCHED_PARITY_EN
        parity_d    = parity;
`endif

        if (state != ST_IDLE && i_tick) begin
            tick_cnt_d = bit_end ? '0 : tick_cnt + 1'b1;
        end

        case (state)
            ST_IDLE: begin
                if (arb_any) begin
                    shift_d     = arb_byte;
                    ptr_d       = arb_idx;
                    grant_idx_d = arb_idx;
                    grant_d     = arb_grant;
                    busy_d      = 1'b1;
                    tick_cnt_d  = '0;
                    state_d     = ST_START;
`ifdef UART_TX_SCHED_PARITY_EN
                    parity_d    = ^arb_byte;
`endif
                end
            end
            ST_START: begin
                if (bit_end) begin
                    bit_cnt_d = '0;
                    state_d   = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    shift_d   = shift_reg >> 1;
                    bit_cnt_d = bit_cnt + 1'b1;
                    if (bit_cnt == BW'(NB_DATA - 1)) begin
`ifdef UART_TX_SCHED_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_SCHED_PARITY_EN
            ST_PARITY: begin
                if (bit_end) begin
                    state_d = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (bit_end) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Line level follows the state being entered so o_tx stays registered.
        case (state_d)
            ST_START:  tx_d = LINE_START;
            ST_DATA:   tx_d = shift_d[0];
`ifdef UART_TX_SCHED_PARITY_EN
            ST_PARITY: tx_d = parity_d;
`endif
            default:   tx_d = LINE_IDLE;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            state       <= ST_IDLE;
            tick_cnt    <= '0;
            bit_cnt     <= '0;
            shift_reg   <= '0;
            ptr         <= NB_IDX'(N_REQ - 1);
            o_grant     <= '0;
            o_grant_idx <= '0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
            o_tx        <= LINE_IDLE;
`ifdef UART_TX_SCHED_PARITY_EN
            parity      <= 1'b0;
`endif
        end else begin
            state       <= state_d;
            tick_cnt    <= tick_cnt_d;
            bit_cnt     <= bit_cnt_d;
            shift_reg   <= shift_d;
            ptr         <= ptr_d;
            o_grant     <= grant_d;
            o_grant_idx <= grant_idx_d;
            o_busy      <= busy_d;
            o_done      <= done_d;
            o_tx        <= tx_d;
`ifdef UART_TX_SCHED_PARITY_EN
            parity      <= parity_d;
`endif
        end
    end

endmodule
